tag_rr_arbiter: RTL and testbench
=================================

# tag_rr_arbiter

Round-robin arbiter that merges NUM_IN untagged valid/ready streams onto one tagged output stream, attaching a per-input configured tag to each accepted word. It is the sharing controller placed in front of a tagged-dataflow consumer: each requester gets a fixed tag from configuration, and the arbiter sequences requesters fairly through a single registered output stage.

## Interface
- NUM_IN, 4: number of requester inputs (≥2).
- DATA_WIDTH, 32: payload width.
- TAG_WIDTH, 4: tag width (≥1).
- IDX_W, $clog2(NUM_IN): derived, grant index width.

- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  NUM_IN  per-requester valid.
- in_ready  out  NUM_IN  per-requester ready; one-hot or zero.
- in_data  in  NUM_IN*DATA_WIDTH  requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- cfg_tag  in  NUM_IN*TAG_WIDTH  tag for requester i at [i*TAG_WIDTH +: TAG_WIDTH].
- cfg_en  in  NUM_IN  requester enable mask; disabled requesters never granted.
- out_valid  out  1  output word held.
- out_ready  in  1  downstream ready.
- out_data  out  TAG_WIDTH+DATA_WIDTH  {tag, data}, tag in MSBs.
- out_src  out  IDX_W  index of requester whose word is held.

## Operation
- Single output register (valid, data, src). load = !out_valid || out_ready.
- Eligible set E = in_valid & cfg_en. If load and E ≠ 0: grant the first eligible index at or after ptr, searching upward with wrap NUM_IN-1 → 0.
- in_ready[g] = load for granted g only; all other in_ready = 0. in_ready is independent of in_valid of non-granted ports.
- On transfer (in_valid[g] && in_ready[g]): out_data ← {cfg_tag[g], in_data[g]}, out_src ← g, out_valid ← 1, ptr ← (g+1) mod NUM_IN.
- If out_valid && out_ready and no eligible requester: out_valid ← 0; out_data/out_src hold previous values.
- ptr changes only on transfer; idle cycles do not rotate priority.
- Tag and data captured at acceptance; later cfg_tag/cfg_en changes do not alter a held word.
- cfg_en deasserted for a port mid-stream: takes effect on next arbitration; already held word still delivered.
- Fairness: a continuously valid enabled requester waits at most NUM_IN-1 transfers.

## Timing
- Reset values: out_valid=0, out_data=0, out_src=0, ptr=0, in_ready=0 while rst=1.
- Latency: 1 cycle from acceptance to out_valid.
- Throughput: 1 word/cycle with out_ready held high.
- in_ready depends combinationally on out_valid, out_ready, in_valid, cfg_en, ptr; out_* are purely registered.
- Backpressure: out_valid=1 and out_ready=0 → all in_ready=0, out_data stable.
- Simultaneous drain and load in one cycle: new word replaces old, out_valid stays 1.
- Reset asserted mid-operation: held word dropped, ptr back to 0 next cycle.

## Configuration
- LOOM_TAG_ARB_PERF_EN defined: adds ports perf_clear (in, 1) and perf_count (out, NUM_IN*16); counter i increments on each transfer from requester i, wraps 0xFFFF → 0; perf_clear (synchronous) zeroes all counters and wins over a same-cycle increment; reset value 0.
- Undefined: ports and counters absent; arbitration behaviour identical.

## Test plan
- Reset: rst=1 3 cycles with all in_valid=1 → out_valid=0, out_data=0, all in_ready=0; after release first grant goes to port 0.
- Tagging: NUM_IN=4, cfg_tag={D,C,B,A}, cfg_en=4'hF, only port 2 valid with 32'hDEAD_BEEF → next cycle out_data={4'hC,32'hDEAD_BEEF}, out_src=2.
- Round-robin: all 4 ports valid continuously, out_ready=1 → out_src sequence 0,1,2,3,0,... one word per cycle.
- Backpressure: out_valid=1, out_ready=0 for 5 cycles → all in_ready=0, out_data unchanged; out_ready=1 → drain and reload same cycle.
- Enable mask: cfg_en=4'b0101, all valid → grants alternate 0,2,0,2; ports 1,3 in_ready never 1.
- PERF_EN: 7 transfers from port 1 → perf_count[1]=7; perf_clear concurrent with a port-1 transfer → perf_count[1]=0.

Source files
------------

// File: rtl/tag_rr_arbiter.sv
// Purpose : round-robin merge of NUM_IN untagged valid/ready streams onto one tagged output stream.
// Latency : 1 cycle from input acceptance to out_valid; 1 word/cycle sustained with out_ready high.
// Backpres: out_valid && !out_ready holds the output register and forces every in_ready low.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  per-requester handshake; in_ready is one-hot or zero
//   in_data            requester i payload at [i*DATA_WIDTH +: DATA_WIDTH]
//   cfg_tag            requester i tag at [i*TAG_WIDTH +: TAG_WIDTH]
//   cfg_en             requester enable mask; disabled requesters are never granted
//   out_valid/out_ready/out_data/out_src
//                      registered output stream; out_data = {tag, data}, out_src = granted index
// Optional (LOOM_TAG_ARB_PERF_EN): perf_clear in, perf_count out (16-bit wrapping counter per requester).

module tag_rr_arbiter #(
   parameter int NUM_IN     = 4,
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 4,
   parameter int IDX_W      = $clog2(NUM_IN)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_IN-1:0]               in_valid,
   output logic [NUM_IN-1:0]               in_ready,
   input  logic [NUM_IN*DATA_WIDTH-1:0]    in_data,
   input  logic [NUM_IN*TAG_WIDTH-1:0]     cfg_tag,
   input  logic [NUM_IN-1:0]               cfg_en,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [TAG_WIDTH+DATA_WIDTH-1:0] out_data,
   output logic [IDX_W-1:0]                out_src
`ifdef LOOM_TAG_ARB_PERF_EN
   ,
   input  logic                            perf_clear,
   output logic [NUM_IN*16-1:0]            perf_count
`endif
);

   localparam logic [IDX_W:0]   NUM_IN_W = (IDX_W+1)'(NUM_IN);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);

   logic                            r_out_valid;
   logic [TAG_WIDTH+DATA_WIDTH-1:0] r_out_data;
   logic [IDX_W-1:0]                r_out_src;
   logic [IDX_W-1:0]                r_ptr;

   logic                  w_load;
   logic [NUM_IN-1:0]     w_elig;
   logic [NUM_IN-1:0]     w_rot;
   logic                  w_found;
   logic [IDX_W-1:0]      w_off;
   logic [IDX_W:0]        w_sum;
   logic [IDX_W:0]        w_wrap;
   logic [IDX_W-1:0]      w_gnt;
   logic [IDX_W-1:0]      w_ptr_nxt;
   logic                  w_xfer;
   logic [DATA_WIDTH-1:0] w_sel_data;
   logic [TAG_WIDTH-1:0]  w_sel_tag;

   assign w_load = !r_out_valid || out_ready;
   assign w_elig = in_valid & cfg_en;

   // Rotate the eligible set so bit 0 corresponds to the current priority pointer;
   // the lowest set bit of the rotated vector is then the winner's offset from ptr.
   assign w_rot = (w_elig >> r_ptr) | (w_elig << (NUM_IN - int'(r_ptr)));

   always_comb begin
      w_found = 1'b0;
      w_off   = '0;
      // Descending scan so the lowest offset is the one left standing.
      for (int k = NUM_IN - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_found = 1'b1;
            w_off   = IDX_W'(k);
         end
      end
   end

   // Winner index = (ptr + offset) mod NUM_IN, done with one conditional subtract
   // so non-power-of-two NUM_IN wraps correctly.
   assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
   assign w_wrap    = w_sum - NUM_IN_W;
   assign w_gnt     = (w_sum >= NUM_IN_W) ? w_wrap[IDX_W-1:0] : w_sum[IDX_W-1:0];
   assign w_ptr_nxt = (w_gnt == LAST_IDX) ? '0 : w_gnt + 1'b1;

   // A grant is only ever issued to an eligible (hence valid) port, so a
   // granted ready is always a transfer. Reset masks the handshake.
   assign w_xfer   = w_load && w_found && !rst;
   assign in_ready = w_xfer ? (NUM_IN'(1) << w_gnt) : '0;

   always_comb begin
      w_sel_data = '0;
      w_sel_tag  = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (w_gnt == IDX_W'(i)) begin
            w_sel_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            w_sel_tag  = cfg_tag[i*TAG_WIDTH +: TAG_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_src   <= '0;
         r_ptr       <= '0;
      end else if (w_xfer) begin
         r_out_valid <= 1'b1;
         r_out_data  <= {w_sel_tag, w_sel_data};
         r_out_src   <= w_gnt;
         r_ptr       <= w_ptr_nxt;
      end else if (w_load) begin
         // Drained (or already empty) with nothing eligible: data/src keep their last value.
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_src   = r_out_src;

`ifdef LOOM_TAG_ARB_PERF_EN
   logic [NUM_IN-1:0][15:0] r_perf;

   always_ff @(posedge clk) begin
      if (rst || perf_clear) begin
         r_perf <= '0;
      end else if (w_xfer) begin
         r_perf[w_gnt] <= r_perf[w_gnt] + 16'd1;
      end
   end

   assign perf_count = r_perf;
`endif

endmodule

// File: tb/tb_tag_rr_arbiter.sv
module tb_tag_rr_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int TW = 4;
   localparam int IW = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [N-1:0]      in_valid = '0;
   logic [N-1:0]      in_ready;
   logic [N*DW-1:0]   in_data = '0;
   logic [N*TW-1:0]   cfg_tag = {4'hD, 4'hC, 4'hB, 4'hA};
   logic [N-1:0]      cfg_en = 4'hF;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [TW+DW-1:0]  out_data;
   logic [IW-1:0]     out_src;
`ifdef LOOM_TAG_ARB_PERF_EN
   logic              perf_clear = 1'b0;
   logic [N*16-1:0]   perf_count;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   tag_rr_arbiter #(.NUM_IN(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .cfg_tag   (cfg_tag),
      .cfg_en    (cfg_en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_src   (out_src)
`ifdef LOOM_TAG_ARB_PERF_EN
      ,
      .perf_clear(perf_clear),
      .perf_count(perf_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model + scoreboard ----------------
   logic [IW+TW+DW-1:0] sb[$];
   logic                m_valid = 1'b0;
   logic [TW+DW-1:0]    m_data  = '0;
   logic [IW-1:0]       m_src   = '0;
   int                  m_ptr   = 0;
   logic                pending = 1'b0;

   function automatic int model_grant(input logic [N-1:0] elig, input int ptr);
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (ptr + k) % N;
         if (elig[idx]) return idx;
      end
      return -1;
   endfunction

   always @(negedge clk) begin
      logic [IW+TW+DW-1:0] e;
      logic [N-1:0]        exp_rdy;
      int                  g;
      // registered outputs reflect the previous rising edge
      if (pending) begin
         e       = sb.pop_front();
         m_src   = e[IW+TW+DW-1 -: IW];
         m_data  = e[TW+DW-1:0];
         pending = 1'b0;
      end
      check("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
      check("out_data", {28'd0, out_data}, {28'd0, m_data});
      check("out_src", {62'd0, out_src}, {62'd0, m_src});
      // predict the coming rising edge
      if (rst) begin
         check("rdy_in_rst", {60'd0, in_ready}, 64'd0);
         m_valid = 1'b0;
         m_data  = '0;
         m_src   = '0;
         m_ptr   = 0;
         sb.delete();
      end else begin
         g       = model_grant(in_valid & cfg_en, m_ptr);
         exp_rdy = '0;
         if ((!m_valid || out_ready) && g >= 0) begin
            exp_rdy[g] = 1'b1;
            sb.push_back({IW'(g), cfg_tag[g*TW +: TW], in_data[g*DW +: DW]});
            pending = 1'b1;
            m_valid = 1'b1;
            m_ptr   = (g + 1) % N;
         end else if (out_ready) begin
            m_valid = 1'b0;
         end
         check("in_ready", {60'd0, in_ready}, {60'd0, exp_rdy});
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic rnd_data();
      for (int i = 0; i < N; i++) in_data[i*DW +: DW] = $urandom;
   endtask

   initial begin
      // reset with every requester asserting valid
      rst = 1'b1; in_valid = 4'hF; cfg_en = 4'hF; out_ready = 1'b1;
      rnd_data();
      repeat (3) cyc();
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_out_data", {28'd0, out_data}, 64'd0);
      rst = 1'b0;
      #1;
      check("first_gnt", {60'd0, in_ready}, 64'd1);

      // round robin, all valid, one word per cycle
      for (int c = 0; c < 8; c++) begin rnd_data(); cyc(); end

      // tagging: only port 2 valid
      in_valid = '0;
      repeat (2) cyc();
      rnd_data();
      in_data[2*DW +: DW] = 32'hDEAD_BEEF;
      in_valid = 4'b0100;
      cyc();
      check("tag_data", {28'd0, out_data}, {28'd0, 4'hC, 32'hDEAD_BEEF});
      check("tag_src", {62'd0, out_src}, 64'd2);
      in_valid = '0;
      cyc();

      // backpressure for 5 cycles then drain+reload
      in_valid = 4'hF;
      rnd_data();
      out_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin rnd_data(); cyc(); end
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin rnd_data(); cyc(); end

      // enable mask: only ports 0 and 2
      cfg_en = 4'b0101;
      for (int c = 0; c < 8; c++) begin rnd_data(); cyc(); end
      // mask change while a word is held under backpressure
      out_ready = 1'b0; cyc();
      cfg_en = 4'b1000; cfg_tag = {4'h1, 4'h2, 4'h3, 4'h4}; cyc();
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin rnd_data(); cyc(); end
      cfg_en = 4'hF;

      // random traffic with a mid-stream reset
      for (int c = 0; c < 60; c++) begin
         rnd_data();
         in_valid  = 4'($urandom);
         cfg_en    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) cfg_tag = 16'($urandom);
         rst = (c == 30);
         cyc();
      end
      rst = 1'b0;
      in_valid = '0; out_ready = 1'b1; cfg_en = 4'hF;
      repeat (2) cyc();

`ifdef LOOM_TAG_ARB_PERF_EN
      perf_clear = 1'b1; cyc(); perf_clear = 1'b0;
      in_valid = 4'b0010;
      for (int c = 0; c < 7; c++) begin rnd_data(); cyc(); end
      in_valid = '0;
      cyc();
      check("perf_cnt7", {48'd0, perf_count[16 +: 16]}, 64'd7);
      in_valid = 4'b0010; perf_clear = 1'b1;
      cyc();
      check("perf_clr", {48'd0, perf_count[16 +: 16]}, 64'd0);
      in_valid = '0; perf_clear = 1'b0;
      cyc();
      check("perf_clr_hold", {48'd0, perf_count[16 +: 16]}, 64'd0);
`endif

      repeat (2) cyc();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
